// File: rtl/ffs_arbiter_pkg.sv
// Shared constants and types for the field-subtractor arbiter: operand width,
// the prime 2^255-19, limb geometry of the subtractor and the arbiter FSM state.
package ffs_arbiter_pkg;

    localparam int FE_W   = 255;
    localparam int LIMB_W = 64;
    localparam int N_LIMB = 4;

    localparam logic [FE_W-1:0] FE_P =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_e;

endpackage

// File: rtl/ffs.sv
// 4-limb field subtractor: out = (a - b) mod 2^255-19 for reduced inputs.
// One limb per cycle after start, then one correction cycle; done is high 6 cycles after start.
module ffs
    import ffs_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [FE_W-1:0] a,
    input  logic [FE_W-1:0] b,
    output logic            done,
    output logic [FE_W-1:0] out
);

    localparam int EXT_W = LIMB_W * N_LIMB;

    logic [2:0]        step;
    logic              borrow;
    logic [EXT_W-1:0]  diff;
    logic [EXT_W-1:0]  a_ext;
    logic [EXT_W-1:0]  b_ext;
    logic [1:0]        limb;
    logic [7:0]        limb_base;
    logic [LIMB_W:0]   limb_diff;

    assign a_ext     = {1'b0, a};
    assign b_ext     = {1'b0, b};
    assign limb      = 2'(step - 3'd1);
    // Limbs are 64 bits wide, so the limb base is the limb number shifted by 6.
    assign limb_base = {limb, 6'd0};
    assign limb_diff = {1'b0, a_ext[limb_base +: LIMB_W]}
                     - {1'b0, b_ext[limb_base +: LIMB_W]}
                     - {{LIMB_W{1'b0}}, borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step   <= 3'd0;
            borrow <= 1'b0;
            diff   <= '0;
            done   <= 1'b0;
            out    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                step   <= 3'd1;
                borrow <= 1'b0;
            end else if (step >= 3'd1 && step <= 3'd4) begin
                diff[limb_base +: LIMB_W] <= limb_diff[LIMB_W-1:0];
                borrow                    <= limb_diff[LIMB_W];
                step                      <= step + 3'd1;
            end else if (step == 3'd5) begin
                // Bit 255 of the 256-bit difference is the sign; adding p wraps mod 2^255.
                out  <= diff[FE_W] ? diff[FE_W-1:0] + FE_P : diff[FE_W-1:0];
                done <= 1'b1;
                step <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/ffs_arb_pick.sv
// Round-robin winner picker: searches upward from last_winner+1 with wrap.
module ffs_arb_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_winner,
    output logic [N_REQ-1:0]         winner,
    output logic                     valid
);

    localparam int IDX_W = $clog2(N_REQ);

    int   idx;
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = int'(last_winner) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                winner[IDX_W'(idx)] = 1'b1;
                found               = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/ffs_arbiter.sv
// Arbiter sharing one field subtractor between N_REQ requesters (IDLE/ISSUE/WAIT).
// Define FFS_ARB_FIXED_PRIO_EN for lowest-index-wins; default build is round-robin.
module ffs_arbiter
    import ffs_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*FE_W-1:0] a_i,
    input  logic [N_REQ*FE_W-1:0] b_i,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [FE_W-1:0]       rsp_data,
    output logic                  busy,
    output arb_state_e            dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e       state, state_n;
    logic [IDX_W-1:0] last_winner;
    logic [N_REQ-1:0] pick_oh;
    logic             pick_valid;
    logic [N_REQ-1:0] win_oh;
    logic [FE_W-1:0]  sel_a, sel_b;
    logic [FE_W-1:0]  op_a, op_b;
    logic [FE_W-1:0]  ffs_out;
    logic             ffs_done;
    logic             grant;

    assign grant = (state == IDLE) && pick_valid;

`ifdef FFS_ARB_FIXED_PRIO_EN
    // Searching from N_REQ-1 upward always starts at requester 0.
    assign last_winner = IDX_W'(N_REQ - 1);
`else
    logic [IDX_W-1:0] pick_id;

    always_comb begin
        pick_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) pick_id = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        last_winner <= IDX_W'(N_REQ - 1);
        else if (grant) last_winner <= pick_id;
    end
`endif

    ffs_arb_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req),
        .last_winner(last_winner),
        .winner     (pick_oh),
        .valid      (pick_valid)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                sel_a = a_i[i*FE_W +: FE_W];
                sel_b = b_i[i*FE_W +: FE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick_valid) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (ffs_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            win_oh    <= '0;
            op_a      <= '0;
            op_b      <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            if (grant) begin
                gnt    <= pick_oh;
                win_oh <= pick_oh;
                op_a   <= sel_a;
                op_b   <= sel_b;
            end
            if (state == WAIT && ffs_done) begin
                rsp_valid <= win_oh;
                rsp_data  <= ffs_out;
            end
        end
    end

    ffs u_ffs (
        .clk  (clk),
        .rst  (rst),
        .start(state == ISSUE),
        .a    (op_a),
        .b    (op_b),
        .done (ffs_done),
        .out  (ffs_out)
    );

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: doc/ffs_arbiter.md
FFS_ARBITER -- requirements
Module: ffs_arbiter

Interface
REQ-001 The block SHALL have one parameter: N_REQ, default 4, number of requesters (legal 2..8).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req  input  N_REQ  per-requester request, level.
REQ-005 a_i  input  N_REQ*255  minuend operands; requester k at bits [255k+254:255k].
REQ-006 b_i  input  N_REQ*255  subtrahend operands, same packing as a_i.
REQ-007 gnt  output  N_REQ  one-hot grant pulse; operands of that requester captured this cycle.
REQ-008 rsp_valid  output  N_REQ  one-hot, one-cycle result strobe to the granted requester.
REQ-009 rsp_data  output  255  (a - b) mod 2^255-19 for the requester flagged in rsp_valid.
REQ-010 busy  output  1  high while a subtraction is in flight (states ISSUE, WAIT).

Function
REQ-011 The block SHALL contain one instance of the 4-limb field subtractor ffs and be its only driver.
REQ-012 FSM states: IDLE, ISSUE, WAIT; IDLE -> ISSUE when any req high; ISSUE -> WAIT after one cycle; WAIT -> IDLE on ffs done.
REQ-013 In IDLE, with any req high, the winner SHALL be chosen round-robin, searching from index last_winner+1 upward with wrap.
REQ-014 On the IDLE->ISSUE edge the block SHALL latch the winner's a and b and the winner id, and register gnt[winner]=1 for exactly one cycle.
REQ-015 ffs start SHALL be high exactly during the ISSUE cycle, with the latched operands on its inputs; operands SHALL stay stable until done.
REQ-016 In WAIT, on the cycle ffs done is high, the block SHALL register rsp_data from ffs out and rsp_valid[id]=1 for one cycle, and return to IDLE.
REQ-017 Latency: rsp_valid SHALL rise exactly 7 cycles after the gnt cycle; the minimum gnt-to-next-gnt spacing is 8 cycles.
REQ-018 rsp_data SHALL hold its value until the next rsp_valid.
REQ-019 Requests arriving in ISSUE or WAIT SHALL be ignored until IDLE; requesters hold req and operands until gnt and drop req the cycle after gnt or get re-served.
REQ-020 A requester deasserting req before gnt SHALL be treated as never having requested.
REQ-021 last_winner SHALL update only on grant; a lone requester is granted on every opportunity.

Reset
REQ-022 rst SHALL force state IDLE, gnt=0, rsp_valid=0, rsp_data=0, busy=0, last_winner=N_REQ-1 (requester 0 highest priority first), latched operands 0, and reset the ffs instance.
REQ-023 rst asserted mid-operation SHALL abort the operation with no rsp_valid; the first grant after release follows REQ-022 priority.

Configuration
REQ-024 Macro FFS_ARB_FIXED_PRIO_EN: when defined, the lowest-index active req SHALL always win and last_winner is not implemented; when undefined, round-robin per REQ-013.

Structure
REQ-025 A shared package SHALL hold the field prime constant (2^255-19), the operand width 255, and the FSM state typedef.
REQ-026 The winner selection SHALL be a separate combinational sub-module ffs_arb_pick (req, last_winner -> one-hot winner and valid).

Verification
REQ-027 Requester 0: a=5, b=3 -> gnt[0] one cycle, rsp_valid[0] 7 cycles later, rsp_data=2.
REQ-028 Requester 1: a=3, b=5 -> rsp_data=2^255-21, rsp_valid[1] only.
REQ-029 All four req high and held -> grants in order 0,1,2,3,0 at 8-cycle spacing, each rsp_valid matching its grant (fixed-prio build: always 0).
REQ-030 rst pulsed 3 cycles after a grant -> no rsp_valid; after release with req[2] high -> gnt[2] and correct result.
REQ-031 req[3] raised during WAIT of requester 1 -> no gnt until IDLE, then gnt[3] on the first IDLE cycle.
REQ-032 a=b=2^255-20 -> rsp_data=0; busy high exactly from the ISSUE cycle through the done cycle.
